seg_display_ctrl: RTL and testbench

Sequencing controller for the board's bank of seven-segment displays. It holds one 4-bit value and one blank flag per digit, accepted through a valid/ready write port. On any change it walks the digits, MSB first, through a single shared hex-to-segment decoder and latches the result into per-digit segment registers. It sits between user logic (counters, menus) and the HEX output pins, and is the only driver of those pins.

---
 rtl/seg_display_ctrl_pkg.sv | 18 +
 rtl/seg_display_ctrl_if.sv | 36 +++
 rtl/seg_display_ctrl_hex_to_seg.sv | 31 +++
 rtl/seg_display_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_display_ctrl_pkg.sv
// rtl/seg_display_ctrl_pkg.sv - shared constants and types for the seven-segment controller
package seg_pkg;

    // Active-low pattern that leaves every segment dark.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Width of a digit index; covers up to eight digits.
    localparam int SEG_IDX_W = 3;

    // Default number of digits on the board.
    localparam int SEG_NUM_DIGITS_DEF = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } seg_state_t;

endpackage

// File: rtl/seg_display_ctrl_if.sv
// rtl/seg_display_ctrl_if.sv - digit write port (wr_blink exists only with SEG_BLINK_EN)
interface seg_display_ctrl_if;
    import seg_pkg::*;

    logic                 wr_valid;
    logic                 wr_ready;
    logic [SEG_IDX_W-1:0] wr_digit;
    logic [3:0]           wr_value;
    logic                 wr_blank;
`ifdef SEG_BLINK_EN
    logic                 wr_blink;
`endif

    modport master (
        output wr_valid,
        output wr_digit,
        output wr_value,
        output wr_blank,
`ifdef SEG_BLINK_EN
        output wr_blink,
`endif
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_digit,
        input  wr_value,
        input  wr_blank,
`ifdef SEG_BLINK_EN
        input  wr_blink,
`endif
        output wr_ready
    );

endinterface

// File: rtl/seg_display_ctrl_hex_to_seg.sv
// rtl/seg_display_ctrl_hex_to_seg.sv - combinational hex digit to active-low segment decoder
module hex_to_seg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Bit 0 is segment A, bit 6 is segment G; a 0 lights the segment.
    always_comb begin
        seg_o = 7'h7F;
        case (hex_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - seven-segment refresh sequencer; SEG_BLINK_EN adds per-digit blinking
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = SEG_NUM_DIGITS_DEF
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_DIV  = 25_000_000
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    seg_display_ctrl_if.slave       wr,
    input  logic                    lz_blank_en,
    output logic [7*NUM_DIGITS-1:0] disp_out,
    output logic                    busy
);

    logic [3:0]            val_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_q;
    logic [6:0]            seg_q [NUM_DIGITS];

    seg_state_t            state_q, state_d;
    logic [SEG_IDX_W-1:0]  idx_q, idx_d;
    logic                  leading_q, leading_d;
    logic                  dirty_q, dirty_d;
    logic                  lz_q;

    logic                  wr_accept;
    logic                  wr_hit;
    logic                  lz_changed;
    logic [3:0]            cur_val;
    logic                  cur_blank;
    logic                  force_blank;
    logic [6:0]            dec_seg;
    logic [6:0]            seg_new;

    // Ready tracks reset directly so the port is usable from the first edge after release.
    assign wr.wr_ready = ~reset;
    assign wr_accept   = wr.wr_valid & wr.wr_ready;
    assign wr_hit      = wr_accept && (int'(wr.wr_digit) < NUM_DIGITS);
    assign lz_changed  = (lz_blank_en != lz_q);

    // Digit register file; out-of-range writes are swallowed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                val_q[d]   <= 4'h0;
                blank_q[d] <= 1'b1;
            end
        end else if (wr_hit) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (wr.wr_digit == SEG_IDX_W'(d)) begin
                    val_q[d]   <= wr.wr_value;
                    blank_q[d] <= wr.wr_blank;
                end
            end
        end
    end

    // Select the digit under the scan pointer for the shared decoder.
    always_comb begin
        cur_val   = 4'h0;
        cur_blank = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx_q == SEG_IDX_W'(d)) begin
                cur_val   = val_q[d];
                cur_blank = blank_q[d];
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .hex_i (cur_val),
        .seg_o (dec_seg)
    );

    // Leading zeros go dark until the first lit nonzero digit; digit 0 always shows.
    assign force_blank = lz_q && leading_q && (cur_val == 4'h0) && !cur_blank &&
                         (idx_q != '0);
    assign seg_new     = (cur_blank || force_blank) ? SEG_BLANK : dec_seg;

    // Scan sequencing: walk from the top digit down, reload if something changed meanwhile.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        leading_d = leading_q;
        case (state_q)
            IDLE: begin
                if (dirty_q) begin
                    state_d   = SCAN;
                    idx_d     = SEG_IDX_W'(NUM_DIGITS - 1);
                    leading_d = 1'b1;
                end
            end
            SCAN: begin
                if (!cur_blank && (cur_val != 4'h0)) begin
                    leading_d = 1'b0;
                end
                if (idx_q == '0) begin
                    if (dirty_q) begin
                        idx_d     = SEG_IDX_W'(NUM_DIGITS - 1);
                        leading_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new change always wins over the clear that happens when a scan is (re)started.
    always_comb begin
        dirty_d = dirty_q;
        if ((state_q == IDLE && dirty_q) || (state_q == SCAN && idx_q == '0 && dirty_q)) begin
            dirty_d = 1'b0;
        end
        if (wr_hit || lz_changed) begin
            dirty_d = 1'b1;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            leading_q <= 1'b1;
            dirty_q   <= 1'b0;
            lz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            leading_q <= leading_d;
            dirty_q   <= dirty_d;
            lz_q      <= lz_blank_en;
        end
    end

    // Latch the decoded pattern into the slot of the digit being scanned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                seg_q[d] <= SEG_BLANK;
            end
        end else if (state_q == SCAN) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (idx_q == SEG_IDX_W'(d)) begin
                    seg_q[d] <= seg_new;
                end
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [NUM_DIGITS-1:0] blink_q;
    logic [CNT_W-1:0]      blink_cnt_q;
    logic                  phase_q;

    // Blink flags follow the register file write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_q <= '0;
        end else if (wr_hit) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (wr.wr_digit == SEG_IDX_W'(d)) begin
                    blink_q[d] <= wr.wr_blink;
                end
            end
        end
    end

    // Free-running half-period counter; phase flips on every wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // Blink masks the latched segments directly, so it needs no rescan.
    always_comb begin
        disp_out = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            disp_out[7*d +: 7] = seg_q[d] | ((phase_q && blink_q[d]) ? SEG_BLANK : 7'h00);
        end
    end
`else
    // Output pins are driven straight from the segment registers.
    always_comb begin
        disp_out = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            disp_out[7*d +: 7] = seg_q[d];
        end
    end
`endif

    assign busy = (state_q == SCAN) | dirty_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb/tb_seg_display_ctrl.sv - scoreboard bench for seg_display_ctrl against a digit-level model
module tb_seg_display_ctrl;

    localparam int N = 6;
    localparam logic [7*N-1:0] ALL_DARK = {(7*N){1'b1}};

    // Lit segments per hex glyph, active-high, bit 0 = A ... bit 6 = G.
    localparam logic [6:0] LIT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           lz_blank_en = 1'b0;
    logic [7*N-1:0] disp_out;
    logic           busy;

    seg_display_ctrl_if wr_if ();

    seg_display_ctrl #(.NUM_DIGITS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr_if),
        .lz_blank_en (lz_blank_en),
        .disp_out    (disp_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_val [N];
    logic       m_blk [N];
    logic       m_lz;

    logic [7*N-1:0] exp_q [$];
    logic           busy_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7*N-1:0] model_disp();
        logic [7*N-1:0] r;
        logic [6:0]     g;
        bit             lead;
        r    = '1;
        lead = 1'b1;
        for (int d = N - 1; d >= 0; d--) begin
            if (m_blk[d])
                g = 7'h7F;
            else if (m_lz && lead && m_val[d] == 4'h0 && d != 0)
                g = 7'h7F;
            else
                g = ~LIT[m_val[d]];
            if (!m_blk[d] && m_val[d] != 4'h0) lead = 1'b0;
            r[7*d +: 7] = g;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            m_val[d] = 4'h0;
            m_blk[d] = 1'b1;
        end
        m_lz = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_op(input int d, input int v, input bit b);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_digit = 3'(d);
        wr_if.wr_value = 4'(v);
        wr_if.wr_blank = b;
        tick();
        wr_if.wr_valid = 1'b0;
        if (d < N) begin
            m_val[d] = 4'(v);
            m_blk[d] = b;
        end
    endtask

    // Count edges until busy drops; returns a large value on timeout.
    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) begin
            errors++;
            checks++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, n);
        end
        tick();
    endtask

    // Monitor: each completed refresh is compared with the oldest expected picture.
    always @(negedge clk) begin
        if (reset) begin
            busy_prev = 1'b0;
        end else begin
            if (busy_prev && !busy) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL scan_unexpected: got %h, expected no refresh", disp_out);
                end else begin
                    chk("scan_result", 64'(disp_out), 64'(exp_q.pop_front()));
                end
            end
            busy_prev = busy;
        end
    end

    initial begin
        int n;
        int busy_hits;
        bit eff;
        int d;

        wr_if.wr_valid = 1'b0;
        wr_if.wr_digit = '0;
        wr_if.wr_value = '0;
        wr_if.wr_blank = 1'b0;
`ifdef SEG_BLINK_EN
        wr_if.wr_blink = 1'b0;
`endif
        model_reset();

        // Reset state
        repeat (2) tick();
        chk("reset_disp", 64'(disp_out), 64'(ALL_DARK));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_ready", 64'(wr_if.wr_ready), 64'(0));
        reset = 1'b0;
        #1;
        chk("ready_after_release", 64'(wr_if.wr_ready), 64'(1));
        repeat (3) tick();
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_disp", 64'(disp_out), 64'(ALL_DARK));

        // Single write: latency of digit 0 and of busy falling
        wr_op(0, 8, 1'b0);
        exp_q.push_back(model_disp());
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (n == N) chk("digit0_not_early", 64'(disp_out[6:0]), 64'h7F);
            if (!busy) break;
        end
        chk("busy_fall_edge", 64'(n), 64'(N + 1));
        chk("single_write_disp", 64'(disp_out), 64'({{(7*(N-1)){1'b1}}, 7'h00}));
        tick();

        // Leading-zero blanking on
        lz_blank_en = 1'b1;
        m_lz = 1'b1;
        wr_op(5, 0, 1'b0);
        wr_op(4, 0, 1'b0);
        wr_op(3, 10, 1'b0);
        wr_op(2, 0, 1'b0);
        wr_op(1, 0, 1'b0);
        wr_op(0, 0, 1'b0);
        exp_q.push_back(model_disp());
        wait_idle("lz_on_idle", n);
        chk("lz_on_disp", 64'(disp_out), 64'({7'h7F, 7'h7F, 7'h08, 7'h40, 7'h40, 7'h40}));

        // Leading-zero toggle alone triggers a rescan
        lz_blank_en = 1'b0;
        m_lz = 1'b0;
        exp_q.push_back(model_disp());
        tick();
        chk("lz_toggle_busy", 64'(busy), 64'(1));
        wait_idle("lz_off_idle", n);
        chk("lz_off_disp", 64'(disp_out), 64'({7'h40, 7'h40, 7'h08, 7'h40, 7'h40, 7'h40}));

        // Write during scan: the scan finishes and a full rescan follows
        wr_op(5, 3, 1'b0);
        tick();
        tick();
        wr_op(2, 15, 1'b0);
        exp_q.push_back(model_disp());
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("rescan_busy_fall", 64'(n), 64'(2 * N + 1 - 3));
        chk("rescan_digit2", 64'(disp_out[20:14]), 64'h0E);
        tick();

        // Out-of-range write: accepted, no effect
        wr_op(7, 8, 1'b0);
        busy_hits = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) busy_hits++;
            tick();
        end
        chk("oor_busy", 64'(busy_hits), 64'(0));
        chk("oor_disp", 64'(disp_out), 64'(model_disp()));

        // Randomized bursts of back-to-back writes and lz toggles
        for (int b = 0; b < 25; b++) begin
            eff = 1'b0;
            for (int o = 0; o < int'($urandom_range(1, 4)); o++) begin
                if ($urandom_range(0, 6) == 0) begin
                    lz_blank_en = ~lz_blank_en;
                    m_lz = lz_blank_en;
                    eff = 1'b1;
                    tick();
                end else begin
                    d = int'($urandom_range(0, 7));
                    wr_op(d, int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
                    if (d < N) eff = 1'b1;
                end
                if ($urandom_range(0, 1) == 1) tick();
            end
            if (eff) exp_q.push_back(model_disp());
            wait_idle("rand_idle", n);
        end

        // Reset in the middle of a scan
        wr_op(1, 5, 1'b0);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("midscan_reset_disp", 64'(disp_out), 64'(ALL_DARK));
        chk("midscan_reset_busy", 64'(busy), 64'(0));
        chk("midscan_reset_ready", 64'(wr_if.wr_ready), 64'(0));
        lz_blank_en = 1'b0;
        model_reset();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("post_reset_disp", 64'(disp_out), 64'(ALL_DARK));
        chk("post_reset_busy", 64'(busy), 64'(0));

        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
